systolic_setup: RTL and testbench
=================================

Name: systolic_setup

Overview:
- Upstream feeder for the N x N weight-stationary systolic matrix array.
- Buffers activation row-vectors arriving over a valid/ready handshake and issues them to the array's per-row systolic inputs, diagonally skewed: row i lags row 0 by i cycles.
- Generates the array's systolic_ctr / FMA_ctr advance enables and flushes the pipeline with zeros after the last vector.

Parameters:
- N, 4, array dimension; number of 8-bit lanes per vector.
- DEPTH, 8, FIFO depth in vectors; power of two, >= 2.
- CNT_W, 8, width of vec_count.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a vector.
- in_ready  output  1  FIFO can accept a vector.
- in_data  input  N*8  vector; lane i = bits [8i+7:8i].
- start  input  1  single-cycle pulse; begin a pass of vec_count vectors.
- vec_count  input  CNT_W  vectors in this pass; sampled when start is accepted.
- busy  output  1  pass in progress.
- done  output  1  one-cycle pulse at end of pass.
- systolic_data  output  N*8  to array systolic_input; lane i feeds row i.
- systolic_ctr  output  1  array advance enable.
- FMA_ctr  output  1  array accumulate enable; always equals systolic_ctr.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - FIFO empty; in_ready=1; busy=0; done=0; systolic_ctr=0; FMA_ctr=0.
  - systolic_data=0; all skew registers 0; FSM=IDLE.
- FIFO:
  - Push when in_valid && in_ready. in_ready = !full, registered occupancy only; no combinational path from in_valid to in_ready.
  - Push and pop in the same cycle: both happen, occupancy unchanged. When full, a same-cycle pop does not raise in_ready until the next cycle.
  - Push is accepted in any FSM state.
- Skew:
  - Lane i has a shift chain of i+1 registers. The chain advances only on cycles where adv=1.
  - systolic_data lane i = tail of chain i. Vector element i appears i+1 advance-cycles after it is injected.
  - When adv=0, all chains hold.
- FSM:
  - IDLE: start with vec_count>0 latches remaining=vec_count, busy=1, goes to STREAM.
  - IDLE: start with vec_count=0 goes to DONE directly; no advance.
  - STREAM, FIFO non-empty: pop, inject the vector, adv=1, remaining-=1. When remaining reaches 0, go to FLUSH with flush_cnt=2N-1.
  - STREAM, FIFO empty: stall; adv=0, chains hold, remaining unchanged.
  - FLUSH: inject zeros, adv=1 each cycle, flush_cnt-=1. At 0, go to DONE. FLUSH never stalls.
  - DONE: done=1 for exactly one cycle, busy=0 from the next cycle, go to IDLE.
- Enables: systolic_ctr = FMA_ctr = registered adv. They align with the systolic_data update of the same edge.
- Start handling: start while busy=1 is ignored, not queued. busy=1 in STREAM, FLUSH, DONE.
- Pass length: a pass with K vectors and no stalls has busy=1 for exactly K + 2N cycles, including the DONE cycle.
- Reset mid-pass: immediate return to reset values. FIFO contents are discarded. The array receives systolic_ctr=0 from that point.

Optional Feature:
- Macro: SYSTOLIC_SETUP_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 16 bits.
  - Increments on every STREAM cycle with FIFO empty; saturates at 16'hFFFF.
  - Clears on reset and on each accepted start.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, N=4: in_ready=1, busy=0, systolic_data=0, systolic_ctr=0 held for 10 cycles.
- Skew check: push vector {lane3..0}=0x04030201, start vec_count=1.
  - Lane0 shows 0x01 one advance after injection; lane1 0x02 after 2; lane2 0x03 after 3; lane3 0x04 after 4.
  - done pulses exactly 9 cycles after start (K+2N=9 busy cycles).
- Stall: start vec_count=3 with 1 vector queued, push the remaining 2 after a 5-cycle gap.
  - systolic_ctr=0 for those 5 cycles; skew outputs frozen.
  - done after 3+8+5 busy cycles; stall_cnt=5 when the macro is defined.
- Full FIFO: push 8 vectors with no start. in_ready=0 after the 8th; a 9th in_valid is not accepted.
  - Start vec_count=8: in_ready returns 1 the cycle after the first pop.
- Edge starts:
  - Start with vec_count=0: done one cycle later, systolic_ctr never asserted.
  - Second start during a pass: ignored; only one done.
- Reset asserted mid-FLUSH: all outputs 0 in the same cycle, without waiting for a clock edge. FIFO empty after release.

Source files
------------

// File: rtl/systolic_setup.sv
// Activation feeder for the N x N weight-stationary systolic array: FIFO, diagonal skew, advance enables.
// Optional SYSTOLIC_SETUP_STALL_CNT_EN adds a 16-bit saturating count of starved STREAM cycles.
module systolic_setup #(
    parameter int N     = 4,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*8-1:0]   in_data,
    input  logic             start,
    input  logic [CNT_W-1:0] vec_count,
    output logic             busy,
    output logic             done,
    output logic [N*8-1:0]   systolic_data,
    output logic             systolic_ctr,
    output logic             FMA_ctr
`ifdef SYSTOLIC_SETUP_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    // state  | meaning
    // IDLE   | waiting for start
    // STREAM | popping vectors into the skew chains, stalls while FIFO empty
    // FLUSH  | injecting zeros for 2N-1 cycles to drain the diagonal
    // DONE   | one-cycle done pulse
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(2 * N);

    state_t state, state_next;

    logic [N*8-1:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, empty, push, pop, adv;
    logic [CNT_W-1:0] remaining;
    logic [FW-1:0]    flush_cnt;
    logic [N*8-1:0]   inj;

    // ---------------- FIFO ----------------
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = (vec_count == '0) ? DONE : STREAM;
            STREAM: if (!empty && remaining == CNT_W'(1)) state_next = FLUSH;
            FLUSH:  if (flush_cnt == FW'(1)) state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop  = 1'b0;
        adv  = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        case (state)
            IDLE:   busy = 1'b0;
            STREAM: begin
                pop = !empty;
                adv = !empty;
            end
            FLUSH:  adv  = 1'b1;
            DONE:   done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == IDLE && start)
                remaining <= vec_count;
            else if (pop)
                remaining <= remaining - 1'b1;

            if (pop && remaining == CNT_W'(1))
                flush_cnt <= FW'(2 * N - 1);
            else if (state == FLUSH)
                flush_cnt <= flush_cnt - 1'b1;
        end
    end

    // ---------------- skew chains ----------------
    assign inj = (state == STREAM) ? mem[rd_ptr] : '0;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [7:0] chain [0:i];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int j = 0; j <= i; j++)
                    chain[j] <= '0;
            end else if (adv) begin
                chain[0] <= inj[8*i +: 8];
                for (int j = 1; j <= i; j++)
                    chain[j] <= chain[j-1];
            end
        end

        assign systolic_data[8*i +: 8] = chain[i];
    end

    // Enables are registered so they land on the same edge as the chain update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            systolic_ctr <= 1'b0;
        else
            systolic_ctr <= adv;
    end

    assign FMA_ctr = systolic_ctr;

`ifdef SYSTOLIC_SETUP_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (state == IDLE && start)
            stall_cnt <= '0;
        else if (state == STREAM && empty && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_systolic_setup.sv
// Directed bench for systolic_setup (N=4, DEPTH=8): reset, skew, stall, full FIFO, edge starts, async reset.
module tb_systolic_setup;

    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [N*8-1:0]   in_data = '0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] vec_count = '0;
    logic             in_ready, busy, done, systolic_ctr, FMA_ctr;
    logic [N*8-1:0]   systolic_data;
`ifdef SYSTOLIC_SETUP_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    systolic_setup #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .start         (start),
        .vec_count     (vec_count),
        .busy          (busy),
        .done          (done),
        .systolic_data (systolic_data),
        .systolic_ctr  (systolic_ctr),
        .FMA_ctr       (FMA_ctr)
`ifdef SYSTOLIC_SETUP_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [N*8-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n);
        start     = 1'b1;
        vec_count = n;
        tick();
        start     = 1'b0;
    endtask

    function automatic logic [31:0] skew_exp(input int c);
        case (c)
            2:       return 32'h0000_0001;
            3:       return 32'h0000_0200;
            4:       return 32'h0003_0000;
            5:       return 32'h0400_0000;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        int done_at;
        int n_done;
        logic [31:0] v;

        // reset and idle
        tick();
        check("reset_outs", {in_ready, busy, done, systolic_ctr, FMA_ctr, systolic_data},
              {1'b1, 4'b0000, 32'h0});
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("idle_c%0d", c), {in_ready, busy, systolic_ctr, systolic_data},
                  {1'b1, 2'b00, 32'h0});
            tick();
        end

        // skew: one vector, pass of 1
        push(32'h0403_0201);
        do_start(8'd1);
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("skew_data_c%0d", c), systolic_data, skew_exp(c));
            check($sformatf("skew_ctr_c%0d", c), {systolic_ctr, FMA_ctr}, (c >= 2) ? 2'b11 : 2'b00);
            check($sformatf("skew_done_c%0d", c), {busy, done}, {1'b1, c == 9});
            tick();
        end
        check("skew_end", {busy, done, systolic_ctr}, 3'b000);

        // stall: 1 queued, 2 more after a 5-cycle starvation
        push(32'h4433_2211);
        do_start(8'd3);
        done_at = 0;
        n_done  = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 6) begin
                in_valid = 1'b1;
                in_data  = 32'h8877_6655;
            end else if (c == 7) begin
                in_data  = 32'hCCBB_AA99;
            end else if (c == 8) begin
                in_valid = 1'b0;
            end
            if (c >= 3 && c <= 7)
                check($sformatf("stall_frozen_c%0d", c), {systolic_ctr, systolic_data}, {1'b0, 32'h0000_0011});
            if (c == 8)
                check("stall_resume_c8", systolic_data, 32'h0000_2255);
            if (c == 9)
                check("stall_resume_c9", systolic_data, 32'h0033_6699);
            if (done) begin
                n_done++;
                if (done_at == 0) done_at = c;
            end
            tick();
        end
        check("stall_done_at", done_at, 16);
        check("stall_done_cnt", n_done, 1);
        check("stall_idle", busy, 1'b0);
`ifdef SYSTOLIC_SETUP_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 16'd5);
`endif

        // full FIFO
        in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            v = {4{8'(32'h20 + k)}};
            in_data = v;
            tick();
            check($sformatf("full_ready_k%0d", k), in_ready, k < 8);
        end
        in_data = 32'hEEEE_EEEE;
        tick();
        check("full_ninth_blocked", in_ready, 1'b0);
        in_valid = 1'b0;
        do_start(8'd8);
        done_at = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) check("full_ready_c1", in_ready, 1'b0);
            if (c == 2) check("full_ready_c2", in_ready, 1'b1);
            if (c >= 2 && c <= 10) begin
                v = (c <= 9) ? 32'(32'h20 + c - 1) : 32'h0;
                check($sformatf("full_lane0_c%0d", c), systolic_data[7:0], v[7:0]);
            end
            if (done && done_at == 0) done_at = c;
            tick();
        end
        check("full_done_at", done_at, 16);

        // start with vec_count = 0
        do_start(8'd0);
        check("zero_c1", {busy, done, systolic_ctr}, 3'b110);
        tick();
        check("zero_c2", {busy, done, systolic_ctr}, 3'b000);
        tick();
        check("zero_c3", systolic_ctr, 1'b0);

        // starts during a pass (STREAM-side and DONE cycle) are ignored
        push(32'h0D0C_0B0A);
        do_start(8'd1);
        done_at = 0;
        n_done  = 0;
        for (int c = 1; c <= 14; c++) begin
            start     = (c == 3 || c == 9);
            vec_count = 8'd5;
            if (done) begin
                n_done++;
                if (done_at == 0) done_at = c;
            end
            tick();
        end
        start = 1'b0;
        check("dbl_done_cnt", n_done, 1);
        check("dbl_done_at", done_at, 9);
        check("dbl_idle", busy, 1'b0);

        // async reset in FLUSH, with one vector left queued
        push(32'h5A5A_5A5A);
        push(32'hA5A5_A5A5);
        do_start(8'd1);
        tick();
        tick();
        tick();
        check("rst_pre_flush", {busy, systolic_ctr, systolic_data}, {2'b11, 32'h005A_0000});
        #2 reset = 1'b1;
        #1;
        check("rst_async_outs", {busy, done, systolic_ctr, FMA_ctr, systolic_data}, {4'b0000, 32'h0});
        check("rst_async_ready", in_ready, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        do_start(8'd1);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("rst_fifo_empty_c%0d", c), {busy, systolic_ctr}, 2'b10);
            tick();
        end
`ifdef SYSTOLIC_SETUP_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 16'd4);
`endif
        reset = 1'b1;
        tick();
        check("final_reset", busy, 1'b0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
